// File: rtl/square_mover.sv
// Position sequencer in front of the square drawer: on each frame tick it
// moves the square by erasing it at the old origin and repainting at the new one.
module square_mover #(
  parameter int SIZE   = 10,
  parameter int X_MAX  = 640,
  parameter int Y_MAX  = 480,
  parameter int STEP   = 1,
  parameter int X_INIT = 20,
  parameter int Y_INIT = 20
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        tick_i,
  input  logic        left_i,
  input  logic        right_i,
  input  logic        up_i,
  input  logic        down_i,
  input  logic        draw_done_i,
  output logic        draw_start_o,
  output logic        draw_setColor_o,
  output logic [10:0] draw_x0_o,
  output logic [10:0] draw_y0_o,
  output logic [10:0] pos_x_o,
  output logic [10:0] pos_y_o,
  output logic        busy_o
);

  typedef enum logic [2:0] {
    S_BOOT,
    S_ERASE_REQ,
    S_ERASE_REL,
    S_DRAW_REQ,
    S_DRAW_REL,
    S_IDLE
  } state_e;

  localparam logic [10:0] X_LIM  = 11'(X_MAX - 1 - SIZE);
  localparam logic [10:0] Y_LIM  = 11'(Y_MAX - 1 - SIZE);
  localparam logic [10:0] STEP_W = 11'(STEP);
  localparam logic [10:0] X_RST  = 11'(X_INIT);
  localparam logic [10:0] Y_RST  = 11'(Y_INIT);

  state_e      state_q;
  logic [10:0] pos_x_q, pos_y_q;
  logic [10:0] next_x_q, next_y_q;
  logic [10:0] next_x_d, next_y_d;
  logic [10:0] sum_x, sum_y;
  logic        moved;

  // Clamped candidate position; opposing requests cancel on each axis.
  always_comb begin
    sum_x    = pos_x_q + STEP_W;
    sum_y    = pos_y_q + STEP_W;
    next_x_d = pos_x_q;
    next_y_d = pos_y_q;
    if (right_i && !left_i)
      next_x_d = (sum_x > X_LIM) ? X_LIM : sum_x;
    else if (left_i && !right_i)
      next_x_d = (pos_x_q < STEP_W) ? 11'd0 : pos_x_q - STEP_W;
    if (down_i && !up_i)
      next_y_d = (sum_y > Y_LIM) ? Y_LIM : sum_y;
    else if (up_i && !down_i)
      next_y_d = (pos_y_q < STEP_W) ? 11'd0 : pos_y_q - STEP_W;
    moved = (next_x_d != pos_x_q) || (next_y_d != pos_y_q);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= S_BOOT;
      pos_x_q  <= X_RST;
      pos_y_q  <= Y_RST;
      next_x_q <= X_RST;
      next_y_q <= Y_RST;
    end else begin
      case (state_q)
        S_BOOT:      state_q <= S_DRAW_REQ;
        S_DRAW_REQ:  if (draw_done_i) state_q <= S_DRAW_REL;
        S_DRAW_REL:  if (!draw_done_i) state_q <= S_IDLE;
        S_IDLE: begin
          if (tick_i && moved) begin
            next_x_q <= next_x_d;
            next_y_q <= next_y_d;
            state_q  <= S_ERASE_REQ;
          end
        end
        S_ERASE_REQ: if (draw_done_i) state_q <= S_ERASE_REL;
        // The origin moves only once the erase handshake has fully closed.
        S_ERASE_REL: begin
          if (!draw_done_i) begin
            pos_x_q <= next_x_q;
            pos_y_q <= next_y_q;
            state_q <= S_DRAW_REQ;
          end
        end
        default:     state_q <= S_BOOT;
      endcase
    end
  end

  assign draw_start_o    = (state_q == S_ERASE_REQ) || (state_q == S_DRAW_REQ);
  assign draw_setColor_o = !((state_q == S_ERASE_REQ) || (state_q == S_ERASE_REL));
  assign busy_o          = (state_q != S_IDLE);
  assign draw_x0_o       = pos_x_q;
  assign draw_y0_o       = pos_y_q;
  assign pos_x_o         = pos_x_q;
  assign pos_y_o         = pos_y_q;

endmodule

// File: doc/square_mover.md
# square_mover

Sequencer that sits directly upstream of the square drawer in the VGA pixel path and owns the on-screen square's position. On each frame tick it samples the direction inputs and computes a clamped new position. If the position changes, it erases the old square, then draws the new one, using the drawer's start/done handshake. It also performs the initial draw after reset.

## Interface
- SIZE, 10, square extent passed to the drawer; the drawer paints x0..x0+SIZE inclusive.
- X_MAX, 640, screen width in pixels.
- Y_MAX, 480, screen height in pixels.
- STEP, 1, pixels moved per tick per axis.
- X_INIT, 20, position x after reset.
- Y_INIT, 20, position y after reset.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- tick  in  1  one-cycle pulse, one per frame.
- left, right, up, down  in  1 each  direction requests; level, sampled only on tick.
- draw_done  in  1  drawer done flag.
- draw_start  out  1  drawer start.
- draw_setColor  out  1  1 = paint square, 0 = erase square.
- draw_x0, draw_y0  out  11  drawer origin; always equals pos_x/pos_y.
- pos_x, pos_y  out  11  current square origin.
- busy  out  1  high in every state except S_IDLE.

## Operation
- States: S_BOOT, S_ERASE_REQ, S_ERASE_REL, S_DRAW_REQ, S_DRAW_REL, S_IDLE.
- Outputs are Moore, decoded from the state register:
  - draw_start = 1 only in S_ERASE_REQ and S_DRAW_REQ.
  - draw_setColor = 0 only in S_ERASE_REQ and S_ERASE_REL; 1 in all other states.
- Reset values: state S_BOOT, pos = (X_INIT, Y_INIT), next = pos, draw_start 0, draw_setColor 1, busy 1.
- Transitions:
  - S_BOOT goes to S_DRAW_REQ unconditionally.
  - S_DRAW_REQ stays until draw_done = 1, then goes to S_DRAW_REL.
  - S_DRAW_REL stays until draw_done = 0, then goes to S_IDLE.
  - S_IDLE: on tick with a position change, latch next_x/next_y and go to S_ERASE_REQ. Otherwise stay in S_IDLE.
  - S_ERASE_REQ stays until draw_done = 1, then goes to S_ERASE_REL.
  - S_ERASE_REL stays until draw_done = 0. On leaving it, pos <= next and the state goes to S_DRAW_REQ.
- Next-position arithmetic (unsigned, 11 bits, per axis independently):
  - right & !left: nx = min(pos_x + STEP, X_MAX-1-SIZE).
  - left & !right: nx = (pos_x < STEP) ? 0 : pos_x - STEP.
  - Both or neither set: nx = pos_x.
  - y uses up (decrement) / down (increment) with the limit Y_MAX-1-SIZE.
- A position change means (nx, ny) != (pos_x, pos_y). A tick whose clamped result equals the current position causes no erase/draw.
- pos changes only on the S_ERASE_REL → S_DRAW_REQ edge. draw_x0/draw_y0 are therefore constant for the whole of each drawer operation.

## Timing
- Tick in S_IDLE at edge N: draw_start = 1 and draw_setColor = 0 from cycle N+1.
- Erase completes when the drawer reports done, followed by at least one cycle with start low before the redraw request.
- A redraw request (S_DRAW_REQ, start high, setColor 1) is never issued while draw_done is still high. This guarantees the drawer has returned to idle first.
- Ticks arriving while busy = 1 are dropped, not queued.
- Direction inputs are ignored except on a tick in S_IDLE.
- Asynchronous reset mid-operation: draw_start drops immediately and pos returns to (X_INIT, Y_INIT). The sequence restarts with an initial draw. A partially drawn or erased square is not cleaned up.
- A draw_done pulse in S_IDLE or S_BOOT is ignored.

## Test plan
All scenarios use a drawer model that asserts done 5 cycles after start rises and clears it 1 cycle after start falls.
1. Reset release with defaults:
   - S_BOOT for 1 cycle, then draw_start = 1 with setColor 1 at (20, 20).
   - busy falls 1 cycle after done clears.
   - Initial draw occurs exactly once.
2. Tick with right = 1 at (20, 20):
   - Erase sequence at (20, 20) with setColor 0.
   - Then draw sequence at (21, 20) with setColor 1.
   - pos = (21, 20) when busy falls.
3. Boundaries:
   - pos (629, 469), tick with right + down: no start pulse, busy stays 0.
   - pos (0, 0), tick with left + up: no start pulse, busy stays 0.
4. Both left and right plus down at (50, 50): a single erase/draw moving to (50, 51).
5. Tick pulses during erase and draw phases: ignored. Exactly one erase plus one draw occurs, and the final pos reflects only the first tick.
6. Reset asserted mid-erase:
   - draw_start goes to 0 in the same cycle.
   - pos = (20, 20).
   - On release, an initial draw at (20, 20) follows.
